// File: rtl/traffic_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : traffic_sequencer
// Purpose  : Core traffic light state machine. Sequences main/side street
//            lights and the pedestrian walk light from a 1 Hz tick, using
//            three runtime-programmable interval registers and a side-street
//            vehicle sensor that can extend green phases.
// Revision : 1.0  initial release
// ============================================================================
// State encoding on o_state_out:
//   0 MAIN_G1, 1 MAIN_G2, 2 MAIN_Y, 3 WALK, 4 SIDE_G, 5 SIDE_GX, 6 SIDE_Y
module traffic_sequencer #(
  parameter int BASE_DEF = 6,
  parameter int EXT_DEF  = 3,
  parameter int YEL_DEF  = 2,
  parameter int TW       = 4
) (
  input  logic          clk,
  input  logic          sys_reset,
  input  logic          i_tick_1hz,
  input  logic          i_reset_db,
  input  logic          i_walk_req_db,
  input  logic          i_reprogram_db,
  input  logic          i_sensor,
  input  logic [1:0]    i_time_sel,
  input  logic [TW-1:0] i_time_value,
  output logic [2:0]    o_main_light,
  output logic [2:0]    o_side_light,
  output logic          o_walk_light,
  output logic          o_walk_pending,
  output logic [2:0]    o_state_out
);

  typedef enum logic [2:0] {
    S_MAIN_G1 = 3'd0,
    S_MAIN_G2 = 3'd1,
    S_MAIN_Y  = 3'd2,
    S_WALK    = 3'd3,
    S_SIDE_G  = 3'd4,
    S_SIDE_GX = 3'd5,
    S_SIDE_Y  = 3'd6
  } state_t;

  localparam logic [2:0] c_RED = 3'b100;
  localparam logic [2:0] c_YEL = 3'b010;
  localparam logic [2:0] c_GRN = 3'b001;

  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_cnt, w_cnt_nxt;
  logic [TW-1:0] r_base, r_ext, r_yel;
  logic [TW-1:0] w_base_nxt, w_ext_nxt, w_yel_nxt, w_prog_val;
  logic          r_walk_pending, w_pend_nxt;
  logic          r_rst_q, r_walk_q, r_rp_q;
  logic          w_rst_edge, w_walk_edge, w_rp_edge, w_prog, w_expire;

  // Button rising edges; a held button yields exactly one event.
  assign w_rst_edge  = i_reset_db     & ~r_rst_q;
  assign w_walk_edge = i_walk_req_db  & ~r_walk_q;
  assign w_rp_edge   = i_reprogram_db & ~r_rp_q;

  // A soft-reset edge in the same cycle suppresses reprogramming.
  assign w_prog     = w_rp_edge & ~w_rst_edge;
  assign w_prog_val = (i_time_value == '0) ? TW'(1) : i_time_value;
  assign w_expire   = i_tick_1hz && (r_cnt == TW'(1));

  // Interval register write decode.
  always_comb begin
    w_base_nxt = r_base;
    w_ext_nxt  = r_ext;
    w_yel_nxt  = r_yel;
    if (w_prog) begin
      case (i_time_sel)
        2'b00:   w_base_nxt = w_prog_val;
        2'b01:   w_ext_nxt  = w_prog_val;
        2'b10:   w_yel_nxt  = w_prog_val;
        default: ;
      endcase
    end
  end

  // Next state, counter reload and walk-pending update in priority order.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_walk_pending;
    if (w_rst_edge) begin
      // Soft reset discards any walk edge arriving alongside it.
      w_state_nxt = S_MAIN_G1;
      w_cnt_nxt   = r_base;
      w_pend_nxt  = 1'b0;
    end else begin
      if (w_rp_edge) begin
        // Restart uses the freshly written base value.
        w_state_nxt = S_MAIN_G1;
        w_cnt_nxt   = w_base_nxt;
      end else if (w_expire) begin
        case (r_state)
          S_MAIN_G1: begin
            w_state_nxt = S_MAIN_G2;
            w_cnt_nxt   = i_sensor ? r_ext : r_base;
          end
          S_MAIN_G2: begin
            w_state_nxt = S_MAIN_Y;
            w_cnt_nxt   = r_yel;
          end
          S_MAIN_Y: begin
            if (r_walk_pending) begin
              w_state_nxt = S_WALK;
              w_cnt_nxt   = r_ext;
              w_pend_nxt  = 1'b0;
            end else begin
              w_state_nxt = S_SIDE_G;
              w_cnt_nxt   = r_base;
            end
          end
          S_WALK: begin
            w_state_nxt = S_SIDE_G;
            w_cnt_nxt   = r_base;
          end
          S_SIDE_G: begin
            if (i_sensor) begin
              w_state_nxt = S_SIDE_GX;
              w_cnt_nxt   = r_ext;
            end else begin
              w_state_nxt = S_SIDE_Y;
              w_cnt_nxt   = r_yel;
            end
          end
          S_SIDE_GX: begin
            w_state_nxt = S_SIDE_Y;
            w_cnt_nxt   = r_yel;
          end
          default: begin
            w_state_nxt = S_MAIN_G1;
            w_cnt_nxt   = r_base;
          end
        endcase
      end else if (i_tick_1hz) begin
        w_cnt_nxt = r_cnt - TW'(1);
      end
      // A new walk edge wins over the clear on WALK entry.
      if (w_walk_edge) begin
        w_pend_nxt = 1'b1;
      end
    end
  end

  // State, timer, interval and edge-history registers.
  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      r_state        <= S_MAIN_G1;
      r_cnt          <= TW'(BASE_DEF);
      r_base         <= TW'(BASE_DEF);
      r_ext          <= TW'(EXT_DEF);
      r_yel          <= TW'(YEL_DEF);
      r_walk_pending <= 1'b0;
      r_rst_q        <= 1'b0;
      r_walk_q       <= 1'b0;
      r_rp_q         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_base         <= w_base_nxt;
      r_ext          <= w_ext_nxt;
      r_yel          <= w_yel_nxt;
      r_walk_pending <= w_pend_nxt;
      r_rst_q        <= i_reset_db;
      r_walk_q       <= i_walk_req_db;
      r_rp_q         <= i_reprogram_db;
    end
  end

  // Moore light decode from the state register.
  always_comb begin
    o_main_light = c_RED;
    o_side_light = c_RED;
    o_walk_light = 1'b0;
    case (r_state)
      S_MAIN_G1, S_MAIN_G2: o_main_light = c_GRN;
      S_MAIN_Y:             o_main_light = c_YEL;
      S_WALK:               o_walk_light = 1'b1;
      S_SIDE_G, S_SIDE_GX:  o_side_light = c_GRN;
      S_SIDE_Y:             o_side_light = c_YEL;
      default: ;
    endcase
  end

  assign o_walk_pending = r_walk_pending;
  assign o_state_out    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_traffic_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_sequencer
// Purpose  : Directed self-checking bench for traffic_sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_traffic_sequencer;

  localparam logic [2:0] ST_G1 = 3'd0, ST_G2 = 3'd1, ST_Y  = 3'd2, ST_WALK = 3'd3;
  localparam logic [2:0] ST_SG = 3'd4, ST_SGX = 3'd5, ST_SY = 3'd6;
  localparam logic [2:0] L_R = 3'b100, L_Y = 3'b010, L_G = 3'b001;

  logic       clk = 1'b0;
  logic       sys_reset = 1'b1;
  logic       tick = 1'b0, reset_db = 1'b0, walk_db = 1'b0, rp_db = 1'b0, sensor = 1'b0;
  logic [1:0] time_sel = 2'b00;
  logic [3:0] time_value = 4'd0;
  logic [2:0] main_light, side_light, state_out;
  logic       walk_light, walk_pending;

  int n_checks = 0;
  int n_pass   = 0;
  int n;
  logic bad_onehot = 1'b0;

  traffic_sequencer #(.BASE_DEF(6), .EXT_DEF(3), .YEL_DEF(2), .TW(4)) dut (
    .clk(clk), .sys_reset(sys_reset), .i_tick_1hz(tick), .i_reset_db(reset_db),
    .i_walk_req_db(walk_db), .i_reprogram_db(rp_db), .i_sensor(sensor),
    .i_time_sel(time_sel), .i_time_value(time_value),
    .o_main_light(main_light), .o_side_light(side_light), .o_walk_light(walk_light),
    .o_walk_pending(walk_pending), .o_state_out(state_out)
  );

  always #5 clk = ~clk;

  // Track the one-light-per-street invariant over the whole run.
  always @(negedge clk) begin
    if (!sys_reset && (!$onehot(main_light) || !$onehot(side_light))) bad_onehot = 1'b1;
  end

  // One tick every 4 clocks; returns at the negedge after the ticking posedge.
  task automatic tick_once();
    repeat (3) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  // Ticks spent in the current state until it changes (bounded).
  task automatic count_ticks(output int cnt);
    logic [2:0] s0;
    s0 = state_out;
    cnt = 0;
    while (state_out == s0 && cnt < 40) begin
      tick_once();
      cnt++;
    end
  endtask

  task automatic pulse_rp(input logic [1:0] sel, input logic [3:0] val, input logic with_walk);
    time_sel = sel; time_value = val; rp_db = 1'b1; walk_db = with_walk;
    @(negedge clk);
    rp_db = 1'b0; walk_db = 1'b0;
  endtask

  task automatic test_reset();
    sys_reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (state_out !== ST_G1) $display("FAIL rst_state got=%0d exp=%0d", state_out, ST_G1); else n_pass++;
    n_checks++; if (main_light !== L_G) $display("FAIL rst_main got=%b exp=%b", main_light, L_G); else n_pass++;
    n_checks++; if (side_light !== L_R) $display("FAIL rst_side got=%b exp=%b", side_light, L_R); else n_pass++;
    n_checks++; if (walk_light !== 1'b0) $display("FAIL rst_walk got=%b exp=0", walk_light); else n_pass++;
    n_checks++; if (walk_pending !== 1'b0) $display("FAIL rst_pend got=%b exp=0", walk_pending); else n_pass++;
    sys_reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_normal_cycle();
    count_ticks(n);
    n_checks++; if (n !== 6) $display("FAIL norm_g1_len got=%0d exp=6", n); else n_pass++;
    n_checks++; if (state_out !== ST_G2 || main_light !== L_G) $display("FAIL norm_g2 st=%0d main=%b exp st=1 main=001", state_out, main_light); else n_pass++;
    count_ticks(n);
    n_checks++; if (n !== 6) $display("FAIL norm_g2_len got=%0d exp=6", n); else n_pass++;
    n_checks++; if (state_out !== ST_Y || main_light !== L_Y || side_light !== L_R) $display("FAIL norm_y st=%0d main=%b side=%b exp st=2 010 100", state_out, main_light, side_light); else n_pass++;
    count_ticks(n);
    n_checks++; if (n !== 2) $display("FAIL norm_y_len got=%0d exp=2", n); else n_pass++;
    n_checks++; if (state_out !== ST_SG || main_light !== L_R || side_light !== L_G) $display("FAIL norm_sg st=%0d main=%b side=%b exp st=4 100 001", state_out, main_light, side_light); else n_pass++;
    count_ticks(n);
    n_checks++; if (n !== 6) $display("FAIL norm_sg_len got=%0d exp=6", n); else n_pass++;
    n_checks++; if (state_out !== ST_SY || side_light !== L_Y || main_light !== L_R) $display("FAIL norm_sy st=%0d main=%b side=%b exp st=6 100 010", state_out, main_light, side_light); else n_pass++;
    count_ticks(n);
    n_checks++; if (n !== 2) $display("FAIL norm_sy_len got=%0d exp=2", n); else n_pass++;
    n_checks++; if (state_out !== ST_G1) $display("FAIL norm_wrap got=%0d exp=0", state_out); else n_pass++;
    n_checks++; if (bad_onehot !== 1'b0) $display("FAIL norm_onehot got=%b exp=0", bad_onehot); else n_pass++;
  endtask

  task automatic test_walk();
    walk_db = 1'b1;
    @(negedge clk);
    walk_db = 1'b0;
    n_checks++; if (walk_pending !== 1'b1) $display("FAIL walk_set got=%b exp=1", walk_pending); else n_pass++;
    count_ticks(n); count_ticks(n); count_ticks(n);
    n_checks++; if (state_out !== ST_WALK) $display("FAIL walk_entry got=%0d exp=3", state_out); else n_pass++;
    n_checks++; if (main_light !== L_R || side_light !== L_R || walk_light !== 1'b1) $display("FAIL walk_lights main=%b side=%b walk=%b exp 100 100 1", main_light, side_light, walk_light); else n_pass++;
    n_checks++; if (walk_pending !== 1'b0) $display("FAIL walk_clr got=%b exp=0", walk_pending); else n_pass++;
    count_ticks(n);
    n_checks++; if (n !== 3) $display("FAIL walk_len got=%0d exp=3", n); else n_pass++;
    n_checks++; if (state_out !== ST_SG || walk_light !== 1'b0) $display("FAIL walk_exit st=%0d walk=%b exp st=4 walk=0", state_out, walk_light); else n_pass++;
    count_ticks(n); count_ticks(n);
  endtask

  task automatic test_sensor();
    sensor = 1'b1;
    count_ticks(n);
    count_ticks(n);
    n_checks++; if (n !== 3) $display("FAIL sens_g2_len got=%0d exp=3", n); else n_pass++;
    count_ticks(n);
    count_ticks(n);
    n_checks++; if (n !== 6) $display("FAIL sens_sg_len got=%0d exp=6", n); else n_pass++;
    n_checks++; if (state_out !== ST_SGX || side_light !== L_G) $display("FAIL sens_sgx st=%0d side=%b exp st=5 side=001", state_out, side_light); else n_pass++;
    sensor = 1'b0;
    count_ticks(n);
    n_checks++; if (n !== 3) $display("FAIL sens_sgx_len got=%0d exp=3", n); else n_pass++;
    n_checks++; if (state_out !== ST_SY) $display("FAIL sens_sy got=%0d exp=6", state_out); else n_pass++;
    count_ticks(n);
  endtask

  task automatic test_reprogram();
    count_ticks(n); count_ticks(n); count_ticks(n);
    tick_once(); tick_once();
    pulse_rp(2'b00, 4'd4, 1'b0);
    n_checks++; if (state_out !== ST_G1 || main_light !== L_G || side_light !== L_R) $display("FAIL rp_restart st=%0d main=%b side=%b exp st=0 001 100", state_out, main_light, side_light); else n_pass++;
    count_ticks(n);
    n_checks++; if (n !== 4) $display("FAIL rp_g1_len got=%0d exp=4", n); else n_pass++;
    count_ticks(n);
    n_checks++; if (n !== 4) $display("FAIL rp_g2_len got=%0d exp=4", n); else n_pass++;
    count_ticks(n);
    n_checks++; if (n !== 2) $display("FAIL rp_y_keep got=%0d exp=2", n); else n_pass++;
    pulse_rp(2'b10, 4'd0, 1'b0);
    n_checks++; if (state_out !== ST_G1) $display("FAIL rp2_restart got=%0d exp=0", state_out); else n_pass++;
    count_ticks(n); count_ticks(n); count_ticks(n);
    n_checks++; if (n !== 1) $display("FAIL rp_y_zero got=%0d exp=1", n); else n_pass++;
    count_ticks(n);
    n_checks++; if (n !== 4) $display("FAIL rp_sg_len got=%0d exp=4", n); else n_pass++;
    count_ticks(n);
    pulse_rp(2'b11, 4'd9, 1'b0);
    count_ticks(n);
    n_checks++; if (n !== 4) $display("FAIL rp_sel11_base got=%0d exp=4", n); else n_pass++;
    count_ticks(n);
    n_checks++; if (n !== 4) $display("FAIL rp_sel11_g2 got=%0d exp=4", n); else n_pass++;
    count_ticks(n); count_ticks(n);
  endtask

  task automatic test_reset_walk();
    n_checks++; if (state_out !== ST_SY) $display("FAIL rw_pre got=%0d exp=6", state_out); else n_pass++;
    reset_db = 1'b1; walk_db = 1'b1;
    @(negedge clk);
    reset_db = 1'b0; walk_db = 1'b0;
    n_checks++; if (state_out !== ST_G1) $display("FAIL rw_state got=%0d exp=0", state_out); else n_pass++;
    n_checks++; if (walk_pending !== 1'b0) $display("FAIL rw_pend got=%b exp=0", walk_pending); else n_pass++;
    count_ticks(n);
    n_checks++; if (n !== 4) $display("FAIL rw_base_kept got=%0d exp=4", n); else n_pass++;
    count_ticks(n); count_ticks(n);
    n_checks++; if (n !== 1) $display("FAIL rw_yel_kept got=%0d exp=1", n); else n_pass++;
    n_checks++; if (state_out !== ST_SG) $display("FAIL rw_no_walk got=%0d exp=4", state_out); else n_pass++;
    count_ticks(n); count_ticks(n);
  endtask

  task automatic test_held_buttons();
    walk_db = 1'b1;
    repeat (60) @(negedge clk);
    n_checks++; if (walk_pending !== 1'b1) $display("FAIL held_set got=%b exp=1", walk_pending); else n_pass++;
    count_ticks(n); count_ticks(n); count_ticks(n);
    n_checks++; if (state_out !== ST_WALK || walk_pending !== 1'b0) $display("FAIL held_walk st=%0d pend=%b exp st=3 pend=0", state_out, walk_pending); else n_pass++;
    count_ticks(n);
    n_checks++; if (state_out !== ST_SG || walk_pending !== 1'b0) $display("FAIL held_single st=%0d pend=%b exp st=4 pend=0", state_out, walk_pending); else n_pass++;
    walk_db = 1'b0;
    @(negedge clk);
    pulse_rp(2'b11, 4'd0, 1'b1);
    n_checks++; if (state_out !== ST_G1 || walk_pending !== 1'b1) $display("FAIL rp_walk st=%0d pend=%b exp st=0 pend=1", state_out, walk_pending); else n_pass++;
    count_ticks(n); count_ticks(n);
    n_checks++; if (state_out !== ST_Y) $display("FAIL pre_sysrst got=%0d exp=2", state_out); else n_pass++;
    tick_once();
    sys_reset = 1'b1;
    #1;
    n_checks++; if (main_light !== L_G || state_out !== ST_G1) $display("FAIL async_rst main=%b st=%0d exp 001 st=0", main_light, state_out); else n_pass++;
    n_checks++; if (walk_pending !== 1'b0) $display("FAIL async_pend got=%b exp=0", walk_pending); else n_pass++;
    @(negedge clk);
    sys_reset = 1'b0;
    count_ticks(n);
    n_checks++; if (n !== 6) $display("FAIL def_base got=%0d exp=6", n); else n_pass++;
    count_ticks(n); count_ticks(n);
    n_checks++; if (n !== 2) $display("FAIL def_yel got=%0d exp=2", n); else n_pass++;
    n_checks++; if (state_out !== ST_SG) $display("FAIL def_no_walk got=%0d exp=4", state_out); else n_pass++;
    sensor = 1'b1;
    count_ticks(n);
    count_ticks(n);
    n_checks++; if (n !== 3) $display("FAIL def_ext got=%0d exp=3", n); else n_pass++;
    sensor = 1'b0;
    n_checks++; if (bad_onehot !== 1'b0) $display("FAIL onehot_all got=%b exp=0", bad_onehot); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_normal_cycle();
    test_walk();
    test_sensor();
    test_reprogram();
    test_reset_walk();
    test_held_buttons();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
